// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values, dispenser state encoding and the
// fault codes also decoded by the vending controller.
package vend_pkg;

  localparam logic [2:0] COIN1_VAL = 3'd1;
  localparam logic [2:0] COIN2_VAL = 3'd2;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_SHORT   = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_FIRE,
    ST_WAIT_ACK,
    ST_DONE,
    ST_FAULT
  } disp_state_e;

endpackage

// File: rtl/coin_inventory.sv
// Per-hopper coin count: saturates at all-ones, never drops below zero, and a
// refill coinciding with a payout leaves the count unchanged.
module coin_inventory #(
  parameter int CNT_W = 4,
  parameter int INIT  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= CNT_W'(INIT);
    end else if (inc && !dec && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/change_dispenser.sv
// Change/refund payout: splits an amount into value-2 and value-1 coins and
// fires the hoppers one coin per ack. Ack timeout under CHANGE_DISPENSER_TIMEOUT_EN.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int INIT1       = 10,
  parameter int INIT2       = 10,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [2:0]       req_amount,
  output logic             req_ready,
  input  logic             clr,
  input  logic             refill1,
  input  logic             refill2,
  output logic             hop1_fire,
  output logic             hop2_fire,
  input  logic             hop_ack,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [2:0]       paid,
  output logic [CNT_W-1:0] inv1,
  output logic [CNT_W-1:0] inv2
);

  disp_state_e state_q;
  logic [2:0]  rem_q, paid_q, coin_q;
  logic [1:0]  fcode_q;
  logic        fire1_q, fire2_q, done_q, fault_q, ready_q;
  logic        ack_take, dec1, dec2;

  assign ack_take = (state_q == ST_WAIT_ACK) && hop_ack;
  assign dec1     = ack_take && (coin_q == COIN1_VAL);
  assign dec2     = ack_take && (coin_q == COIN2_VAL);

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  logic [TMR_W-1:0] tmr_q;
`else
  logic unused_timeout;
  assign unused_timeout = (ACK_TIMEOUT > 0);
`endif

  // IDLE wait req | SELECT pick coin | FIRE eject | WAIT_ACK await drop | DONE pulse | FAULT hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      paid_q  <= '0;
      coin_q  <= '0;
      fcode_q <= FC_NONE;
      fire1_q <= 1'b0;
      fire2_q <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      ready_q <= 1'b1;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
      tmr_q   <= '0;
`endif
    end else begin
      fire1_q <= 1'b0;
      fire2_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            rem_q   <= req_amount;
            paid_q  <= '0;
            fcode_q <= FC_NONE;
            ready_q <= 1'b0;
            state_q <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (rem_q == 3'd0) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if ((rem_q >= COIN2_VAL) && (inv2 != '0)) begin
            coin_q  <= COIN2_VAL;
            fire2_q <= 1'b1;
            state_q <= ST_FIRE;
          end else if (inv1 != '0) begin
            coin_q  <= COIN1_VAL;
            fire1_q <= 1'b1;
            state_q <= ST_FIRE;
          end else begin
            fcode_q <= FC_SHORT;
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end
        end
        ST_FIRE: begin
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
          tmr_q   <= '0;
`endif
          state_q <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (hop_ack) begin
            rem_q   <= rem_q - coin_q;
            paid_q  <= paid_q + coin_q;
            state_q <= ST_SELECT;
          end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
          else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
            fcode_q <= FC_TIMEOUT;
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_FAULT: begin
          if (clr) begin
            fault_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  coin_inventory #(.CNT_W(CNT_W), .INIT(INIT1)) u_inv1 (
    .clk(clk), .rst(rst), .inc(refill1), .dec(dec1), .count(inv1)
  );

  coin_inventory #(.CNT_W(CNT_W), .INIT(INIT2)) u_inv2 (
    .clk(clk), .rst(rst), .inc(refill2), .dec(dec2), .count(inv2)
  );

  assign req_ready  = ready_q;
  assign hop1_fire  = fire1_q;
  assign hop2_fire  = fire2_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_code = fcode_q;
  assign paid       = paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed payout scenarios plus randomized traffic,
// checked every cycle against a transaction-level payout model.
module tb_change_dispenser;

  localparam int INV_MAX = 15;
  localparam int TMO     = 8;
  localparam int P_IDLE = 0, P_SEL = 1, P_FIRE = 2, P_WAIT = 3, P_DONE = 4, P_FAULT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_amount = '0;
  logic       req_ready;
  logic       clr = 1'b0;
  logic       refill1 = 1'b0;
  logic       refill2_drv = 1'b0;
  logic       ack_refill = 1'b0;
  logic       refill2;
  logic       hop1_fire, hop2_fire;
  logic       hop_ack = 1'b0;
  logic       done, fault;
  logic [1:0] fault_code;
  logic [2:0] paid;
  logic [3:0] inv1, inv2;

  assign refill2 = refill2_drv | ack_refill;

  change_dispenser #(.CNT_W(4), .INIT1(10), .INIT2(10), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .clr(clr), .refill1(refill1), .refill2(refill2),
    .hop1_fire(hop1_fire), .hop2_fire(hop2_fire), .hop_ack(hop_ack),
    .done(done), .fault(fault), .fault_code(fault_code), .paid(paid),
    .inv1(inv1), .inv2(inv2)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0, cyc = 0;
  int ack_mode = 1;          // 0 random, 1 ack at first chance, 2 never, 4 always high
  bit refill_on_ack = 1'b0;
  bit cmp_en = 1'b1;

  // Transaction-level model: what has been paid, what is owed, coins on hand.
  int  m_ph, m_rem, m_paid, m_coin, m_fc, m_inv1, m_inv2, m_wait;
  bit  m_acc;
  int  o_inv1, o_inv2, d1, d2;

  function automatic int clamp(input int v);
    return (v > INV_MAX) ? INV_MAX : ((v < 0) ? 0 : v);
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = P_IDLE; m_rem = 0; m_paid = 0; m_coin = 0; m_fc = 0;
      m_inv1 = 10; m_inv2 = 10; m_wait = 0; m_acc = 1'b0;
    end else begin
      o_inv1 = m_inv1; o_inv2 = m_inv2; d1 = 0; d2 = 0; m_acc = 1'b0;
      case (m_ph)
        P_IDLE: if (req_valid) begin
          m_acc = 1'b1; m_rem = int'(req_amount); m_paid = 0; m_fc = 0; m_ph = P_SEL;
        end
        P_SEL: begin
          if (m_rem == 0)                      m_ph = P_DONE;
          else if (m_rem >= 2 && o_inv2 > 0) begin m_coin = 2; m_ph = P_FIRE; end
          else if (o_inv1 > 0)                begin m_coin = 1; m_ph = P_FIRE; end
          else                                begin m_fc = 1; m_ph = P_FAULT; end
        end
        P_FIRE: begin m_wait = 0; m_ph = P_WAIT; end
        P_WAIT: begin
          if (hop_ack) begin
            m_rem -= m_coin; m_paid += m_coin;
            if (m_coin == 1) d1 = 1; else d2 = 1;
            m_ph = P_SEL;
          end else begin
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
            m_wait++;
            if (m_wait == TMO) begin m_fc = 2; m_ph = P_FAULT; end
`endif
          end
        end
        P_DONE:  m_ph = P_IDLE;
        P_FAULT: if (clr) m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
      m_inv1 = clamp(o_inv1 + int'(refill1) - d1);
      m_inv2 = clamp(o_inv2 + int'(refill2) - d2);
    end
  end

  // Ack / same-cycle refill driver
  always begin
    @(posedge clk); #1;
    case (ack_mode)
      1:       hop_ack = (m_ph == P_WAIT);
      2:       hop_ack = 1'b0;
      4:       hop_ack = 1'b1;
      default: hop_ack = ($urandom_range(0, 2) == 0);
    endcase
    ack_refill = refill_on_ack && hop_ack && (m_ph == P_WAIT);
  end

  // Per-cycle compare plus event monitors for directed timing checks
  int n_f1, n_f2, t_h1, t_h2, t_done, t_fault, e0;
  logic [17:0] exp_v, act_v;
  always @(negedge clk) begin
    if (rst === 1'b1 && cmp_en) begin
      exp_v = {m_ph == P_IDLE, m_ph == P_FIRE && m_coin == 1, m_ph == P_FIRE && m_coin == 2,
               m_ph == P_DONE, m_ph == P_FAULT, 2'(m_fc), 3'(m_paid), 4'(m_inv1), 4'(m_inv2)};
      act_v = {req_ready, hop1_fire, hop2_fire, done, fault, fault_code, paid, inv1, inv2};
      n_vec++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_cmp @%0d: dut=%h model=%h (rdy,f1,f2,done,fault,fc,paid,inv1,inv2)",
                 cyc, act_v, exp_v);
      end
    end
    if (hop1_fire === 1'b1) begin n_f1++; if (t_h1 < 0) t_h1 = cyc; end
    if (hop2_fire === 1'b1) begin n_f2++; if (t_h2 < 0) t_h2 = cyc; end
    if (done === 1'b1 && t_done < 0) t_done = cyc;
    if (fault === 1'b1 && t_fault < 0) t_fault = cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_req(input int amt);
    n_f1 = 0; n_f2 = 0; t_h1 = -1; t_h2 = -1; t_done = -1; t_fault = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_amount = 3'(amt);
    @(posedge clk); #1;
    e0 = cyc; req_valid = 1'b0;
  endtask

  task automatic pay(input int amt);
    int i;
    start_req(amt);
    i = 0;
    while (!(m_ph == P_IDLE || m_ph == P_FAULT) && i < 200) begin
      @(posedge clk); #1; i++;
    end
    check("pay_complete", (m_ph == P_IDLE || m_ph == P_FAULT), 1);
    @(negedge clk); #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_fires", {hop1_fire, hop2_fire, done, fault}, 0);
    check("rst_inv1", inv1, 10);
    check("rst_inv2", inv2, 10);
    @(negedge clk); rst = 1'b1;

    // amount 3, immediate acks: value-2 then value-1 coin
    ack_mode = 1;
    pay(3);
    check("a3_h2_time", t_h2 - e0, 1);
    check("a3_h1_time", t_h1 - e0, 4);
    check("a3_done_time", t_done - e0, 7);
    check("a3_fire_counts", {n_f1[3:0], n_f2[3:0]}, {4'd1, 4'd1});
    check("a3_paid", paid, 3);
    check("a3_inv", {inv1, inv2}, {4'd9, 4'd9});
    check("a3_model_paid", m_paid, 3);

    // drain value-2 hopper, then value-1 coins substitute
    @(negedge clk); rst = 1'b0; @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 10; k++) pay(2);
    check("drain_inv2", inv2, 0);
    pay(4);
    check("sub_fire1", n_f1, 4);
    check("sub_fire2", n_f2, 0);
    check("sub_paid", paid, 4);
    check("sub_inv1", inv1, 6);
    check("sub_done_seen", t_done >= 0, 1);

    // both hoppers empty: inventory-short fault
    pay(6);
    check("drain_inv1", inv1, 0);
    pay(1);
    check("short_time", t_fault - e0, 1);
    check("short_code", fault_code, 1);
    check("short_paid", paid, 0);
    check("short_nofire", n_f1 + n_f2, 0);
    pulse_clr();
    check("clr_ready", req_ready, 1);
    check("clr_code_hold", {fault, fault_code}, {1'b0, 2'b01});

    pay(0);
    check("a0_done_time", t_done - e0, 1);
    check("a0_paid", paid, 0);

    // refill coinciding with a value-2 ack, then saturation
    @(posedge clk); #1; refill2_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1; refill2_drv = 1'b0;
    check("refill_inv2", inv2, 3);
    refill_on_ack = 1'b1;
    pay(2);
    refill_on_ack = 1'b0;
    check("refill_ack_inv2", inv2, 3);
    check("refill_ack_paid", paid, 2);
    @(posedge clk); #1; refill2_drv = 1'b1; refill1 = 1'b1;
    repeat (20) @(posedge clk);
    #1; refill2_drv = 1'b0; refill1 = 1'b0;
    check("sat_inv2", inv2, 15);
    check("sat_inv1", inv1, 15);

    // withheld ack
    ack_mode = 2;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    pay(2);
    check("tmo_time", t_fault - e0, 10);
    check("tmo_code", fault_code, 2);
    check("tmo_paid", paid, 0);
    check("tmo_inv2", inv2, 15);
    pulse_clr();
    start_req(2);
    repeat (4) @(posedge clk);
`else
    start_req(2);
    repeat (30) @(posedge clk);
    #1;
    check("hang_fire2", n_f2, 1);
    check("hang_state", {req_ready, fault, paid}, 0);
    check("hang_nodone", t_done, -1);
`endif

    // reset while awaiting an ack, then a late ack
    #3; rst = 1'b0; #1;
    check("midrst_ready", req_ready, 1);
    check("midrst_outs", {hop1_fire, hop2_fire, done, fault, fault_code, paid}, 0);
    check("midrst_inv", {inv1, inv2}, {4'd10, 4'd10});
    @(negedge clk); rst = 1'b1;
    ack_mode = 4;
    repeat (2) @(posedge clk);
    #1; ack_mode = 2;
    @(negedge clk); #1;
    check("late_ack_inv", {inv1, inv2}, {4'd10, 4'd10});
    check("late_ack_paid", paid, 0);
    check("late_ack_ready", req_ready, 1);

    // randomized traffic
    ack_mode = 0;
    repeat (4000) begin
      @(posedge clk); #1;
      if (req_valid && m_acc) req_valid = 1'b0;
      else if (!req_valid && $urandom_range(0, 3) == 0) begin
        req_valid = 1'b1; req_amount = 3'($urandom_range(0, 7));
      end
      refill1     = ($urandom_range(0, 9) == 0);
      refill2_drv = ($urandom_range(0, 7) == 0);
      clr         = ($urandom_range(0, 5) == 0);
    end
    begin
      int i;
      @(posedge clk); #1;
      req_valid = 1'b0; refill1 = 1'b0; refill2_drv = 1'b0; clr = 1'b1; ack_mode = 1;
      i = 0;
      while (m_ph != P_IDLE && i < 60) begin @(posedge clk); #1; i++; end
      clr = 1'b0;
      @(negedge clk); #1;
      check("final_idle", req_ready, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin payout unit at the far end of the vending controller's change/return path. It accepts a 3-bit amount in coin units (change after a sale or refund after a cancel), splits it into value-2 and value-1 coins, and fires two coin hoppers one coin at a time under an ack handshake. It tracks per-hopper inventory and reports completion or fault back to the controller.

## Interface
- CNT_W, 4, inventory counter width; saturates at 2^CNT_W-1
- INIT1, 10, value-1 hopper inventory after reset
- INIT2, 10, value-2 hopper inventory after reset
- ACK_TIMEOUT, 8, cycles allowed in WAIT_ACK before timeout fault

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  payout request; requester holds it until accepted
- req_amount  in  3  amount to pay out, 0..7 units
- req_ready  out  1  high in IDLE only
- clr  in  1  fault clear pulse; ignored outside FAULT
- refill1, refill2  in  1  add one coin to the value-1 / value-2 inventory
- hop1_fire, hop2_fire  out  1  one-cycle coin eject command to the value-1 / value-2 hopper
- hop_ack  in  1  hopper reports a coin dropped
- done  out  1  one-cycle pulse when the full amount has been paid
- fault  out  1  high while in FAULT
- fault_code  out  2  00 none, 01 inventory short, 10 ack timeout
- paid  out  3  units dispensed in the current transaction
- inv1, inv2  out  CNT_W  current inventory

## Operation
- States: IDLE, SELECT, FIRE, WAIT_ACK, DONE, FAULT.
- IDLE: req_ready=1. On req_valid&req_ready: remaining<=req_amount, paid<=0, fault_code<=00, go to SELECT.
- SELECT:
  - remaining==0: go to DONE.
  - remaining>=2 and inv2>0: coin_sel<=2, go to FIRE.
  - else remaining>=1 and inv1>0: coin_sel<=1, go to FIRE. A value-1 coin substitutes for an empty value-2 hopper.
  - else: fault_code<=01, go to FAULT.
- FIRE: hopN_fire=1 for the selected hopper only, exactly one cycle; go to WAIT_ACK. Timer is cleared here.
- WAIT_ACK:
  - hop_ack: remaining-=coin_sel, paid+=coin_sel, selected inventory decremented, go to SELECT.
  - No ack for ACK_TIMEOUT cycles: fault_code<=10, go to FAULT. Paid and inventory are not updated.
  - hop_ack in any other state is ignored.
- DONE: done=1 for one cycle, then go to IDLE.
- FAULT: fault=1, req_ready=0. clr goes to IDLE; fault_code and paid hold until the next accept.
- Inventory:
  - Refill saturates at max.
  - Refill and decrement of the same hopper in the same cycle leave the count unchanged.
  - Decrement never underflows, because SELECT checks for nonzero inventory first.
- Arithmetic: remaining and paid are 3-bit. paid+remaining always equals the accepted amount, so no overflow occurs.

## Timing
- Reset (rst low), asynchronous:
  - State IDLE, remaining=0, paid=0, fault_code=00, timer=0.
  - inv1=INIT1, inv2=INIT2.
  - hop1_fire=hop2_fire=done=fault=0, req_ready=1.
- All outputs are Moore-decoded from registered state; none depend combinationally on inputs.
- Accept on edge E0 → SELECT; FIRE at E1 (fire high during cycle E1–E2); WAIT_ACK from E2.
- An ack sampled at edge Ek → SELECT at Ek, FIRE at Ek+1.
- Amount 3 with ack in the first WAIT_ACK cycle each time: hop2_fire after E1, hop1_fire after E4, DONE state after E7, done pulse during E7–E8, IDLE at E8.
- Amount 0: done pulse two cycles after accept.
- Reset mid-transaction aborts immediately. A pending coin is not counted.

## Configuration
- CHANGE_DISPENSER_TIMEOUT_EN defined: the ACK_TIMEOUT timer is present and fault_code 10 is reachable.
- Not defined: no timer logic; WAIT_ACK waits indefinitely for hop_ack and fault_code is only ever 00 or 01.

## Structure
- Shared package vend_pkg holds:
  - Coin value constants COIN1_VAL=1 and COIN2_VAL=2.
  - The dispenser state enum.
  - Fault code constants, shared with the vending controller.
- One sub-module, coin_inventory: saturating up/down counter with INIT parameter, inc, dec and count ports. It is instantiated twice.

## Test plan
- After reset, inv1=10 and inv2=10; request amount 3 with immediate acks → one hop2_fire then one hop1_fire, done pulse at E7, paid=3, inv2=9, inv1=9.
- inv2=0, request 4 → four hop1_fire pulses, no hop2_fire, done, paid=4, inv1=6.
- inv1=0 and inv2=0, request 1 → no fire, fault=1 with fault_code=01 two cycles after accept, paid=0; clr returns to IDLE with req_ready=1.
- With the macro defined, withhold hop_ack after the first fire of amount 2 → fault_code=10 after 8 WAIT_ACK cycles, paid=0, inv2 unchanged. Without the macro, the FSM stays in WAIT_ACK.
- refill2 pulsed in the same cycle as a value-2 ack → inv2 unchanged. Refill at 15 → stays 15.
- Assert rst low during WAIT_ACK → immediately IDLE, all outputs at reset values, inventories at INIT. A late hop_ack after release causes no change.
